// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM request controller and its helpers.
package sram_ctrl_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;
  localparam int BE_W       = DEF_DATA_W / 8;

  // Byte-enable value that selects every byte of a default-width word.
  localparam logic [BE_W-1:0] FULL_BE = '1;

  typedef enum logic [2:0] {
    S_CLEAR    = 3'd0,
    S_IDLE     = 3'd1,
    S_RD       = 3'd2,
    S_RD_WAIT  = 3'd3,
    S_WR       = 3'd4,
    S_MERGE_WR = 3'd5,
    S_RSP      = 3'd6
  } state_t;

endpackage

// File: rtl/sram_byte_merge.sv
// Per-byte select between an old word and a new word under a byte mask.
// Purely combinational so it can sit in any read-modify-write path.
module sram_byte_merge
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0]   old_data,
  input  logic [DATA_W-1:0]   new_data,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   merged_data
);

  // Start from the old word and overwrite each enabled byte with new data.
  always_comb begin
    merged_data = old_data;
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (be[i]) merged_data[8*i +: 8] = new_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// Request-side controller for a single-port word SRAM without byte enables.
// Zero-fills the array after reset, then serves one load/store at a time,
// doing read-modify-write for partially masked stores.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is high only while idle, and all req_*
// fields are captured on that edge. rsp_valid is a one-cycle pulse with no
// backpressure; rsp_rdata is valid in that cycle.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int INIT_CLEAR = 1
) (
  input  logic                clk,
  input  logic                res,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                init_done,
  output logic                sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata,
  output logic [2:0]          dbg_state
);

  localparam int BW = DATA_W / 8;
  localparam logic [BW-1:0] FULL_MASK = '1;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   clr_cnt;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [BW-1:0]       be_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   merge_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   merged;
  logic                accept;
  logic                we_c;
  logic [ADDR_W-1:0]   addr_c;
  logic [DATA_W-1:0]   wdata_c;

  // Handshake-visible status is gated by reset so it reads 0 during reset.
  assign req_ready = (state == S_IDLE) && !res;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == S_RSP) && !res;
  assign init_done = (state != S_CLEAR) && !res;
  assign rsp_rdata = rdata_q;
  assign dbg_state = state;

  // The SRAM must never see a write while reset is held.
  assign sram_we    = we_c && !res;
  assign sram_addr  = addr_c;
  assign sram_wdata = wdata_c;

  sram_byte_merge #(
    .DATA_W (DATA_W)
  ) u_merge (
    .old_data    (sram_rdata),
    .new_data    (wdata_q),
    .be          (be_q),
    .merged_data (merged)
  );

  // State register; reset restarts the clear unless it is disabled.
  always_ff @(posedge clk) begin
    if (res) state <= (INIT_CLEAR != 0) ? S_CLEAR : S_IDLE;
    else     state <= state_nx;
  end

  // Clear address counter, one word per cycle while clearing.
  always_ff @(posedge clk) begin
    if (res)                    clr_cnt <= '0;
    else if (state == S_CLEAR)  clr_cnt <= clr_cnt + ADDR_W'(1);
  end

  // Request register, loaded only on an accepted handshake.
  always_ff @(posedge clk) begin
    if (res) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      be_q    <= req_be;
      wdata_q <= req_wdata;
    end
  end

  // Response and merge registers: capture read data or the word being written.
  always_ff @(posedge clk) begin
    if (res) begin
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        S_RD_WAIT: begin
          if (we_q) begin
            merge_q <= merged;
            rdata_q <= merged;
          end else begin
            rdata_q <= sram_rdata;
          end
        end
        S_WR:    rdata_q <= wdata_q;
        default: ;
      endcase
    end
  end

  // Next-state and SRAM pin decode.
  always_comb begin
    state_nx = state;
    we_c     = 1'b0;
    addr_c   = addr_q;
    wdata_c  = '0;
    case (state)
      S_CLEAR: begin
        we_c   = 1'b1;
        addr_c = clr_cnt;
        if (clr_cnt == {ADDR_W{1'b1}}) state_nx = S_IDLE;
      end
      S_IDLE: begin
        if (accept) begin
          if (!req_we)                 state_nx = S_RD;
          else if (req_be == '0)       state_nx = S_RSP;
          else if (req_be == FULL_MASK) state_nx = S_WR;
          else                         state_nx = S_RD;
        end
      end
      S_RD:      state_nx = S_RD_WAIT;
      // Only partial stores take the read path besides loads.
      S_RD_WAIT: state_nx = we_q ? S_MERGE_WR : S_RSP;
      S_WR: begin
        we_c     = 1'b1;
        wdata_c  = wdata_q;
        state_nx = S_RSP;
      end
      S_MERGE_WR: begin
        we_c     = 1'b1;
        wdata_c  = merge_q;
        state_nx = S_RSP;
      end
      S_RSP:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: SRAM array model, behavioural reference checked every
// cycle, directed scenarios with literal expectations, and random traffic.
module tb_sram_ctrl;

  localparam int DEPTH = 256;

  logic        clk;
  logic        res;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        init_done;
  logic        sram_we;
  logic [7:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  sram_ctrl #(
    .ADDR_W     (8),
    .DATA_W     (32),
    .INIT_CLEAR (1)
  ) dut (
    .clk        (clk),
    .res        (res),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_be     (req_be),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .init_done  (init_done),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset bookkeeping ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc = index of the current cycle counted from the first cycle with res=0
  int   cyc = 0;
  logic res_q = 1'b0;
  always @(posedge clk) begin
    res_q <= res;
    if (res) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // ---------------- SRAM array (registered read) ----------------
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_wdata;
    sram_rdata <= mem[sram_addr];
  end

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_q [$];
  int          busy_until = -1;
  int          rsp_cyc    = -1;
  int          wr_cyc     = -1;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] last_rdata = '0;
  int          rsp_cnt    = 0;

  // Compare every cycle at the falling edge, then advance the model.
  always @(negedge clk) begin : compare
    logic        exp_ready;
    logic        exp_rsp;
    logic [31:0] m;
    logic [31:0] e;
    if (rsp_valid) rsp_cnt++;
    if (res) begin
      chk1("rst_we", sram_we, 1'b0);
      chk1("rst_ready", req_ready, 1'b0);
      chk1("rst_rsp_valid", rsp_valid, 1'b0);
      chk1("rst_init_done", init_done, 1'b0);
      if (res_q) begin
        chk("rst_sram_addr", 32'(sram_addr), 32'h0);
        chk("rst_sram_wdata", sram_wdata, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      end
      busy_until = -1;
      rsp_cyc    = -1;
      wr_cyc     = -1;
      last_rdata = '0;
      exp_q.delete();
    end else if (cyc < DEPTH) begin
      chk1("clr_we", sram_we, 1'b1);
      chk("clr_addr", 32'(sram_addr), 32'(cyc));
      chk("clr_wdata", sram_wdata, 32'h0);
      chk1("clr_ready", req_ready, 1'b0);
      chk1("clr_init_done", init_done, 1'b0);
      chk1("clr_rsp_valid", rsp_valid, 1'b0);
      ref_mem[cyc] = '0;
    end else begin
      exp_ready = (cyc > busy_until);
      exp_rsp   = (cyc == rsp_cyc);
      chk1("init_done", init_done, 1'b1);
      chk1("req_ready", req_ready, exp_ready);
      chk1("rsp_valid", rsp_valid, exp_rsp);
      chk1("sram_we", sram_we, (cyc == wr_cyc));
      if (exp_rsp && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e);
        last_rdata = e;
      end
      if (cyc == wr_cyc) begin
        chk("wr_addr", 32'(sram_addr), 32'(wr_addr));
        chk("wr_data", sram_wdata, wr_data);
        ref_mem[wr_addr] = wr_data;
      end
      if (req_valid && exp_ready) begin
        if (!req_we) begin
          exp_q.push_back(ref_mem[req_addr]);
          rsp_cyc = cyc + 3;
        end else if (req_be == 4'h0) begin
          exp_q.push_back(last_rdata);
          rsp_cyc = cyc + 1;
        end else if (req_be == 4'hF) begin
          wr_cyc  = cyc + 1;
          wr_addr = req_addr;
          wr_data = req_wdata;
          exp_q.push_back(req_wdata);
          rsp_cyc = cyc + 2;
        end else begin
          m = ref_mem[req_addr];
          for (int i = 0; i < 4; i++) begin
            if (req_be[i]) m[8*i +: 8] = req_wdata[8*i +: 8];
          end
          wr_cyc  = cyc + 3;
          wr_addr = req_addr;
          wr_data = m;
          exp_q.push_back(m);
          rsp_cyc = cyc + 4;
        end
        busy_until = rsp_cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_init(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!init_done && n < 400);
    if (!init_done) chk("init_timeout", {29'h0, dbg_state}, 32'hFFFF_FFFF);
    else            chk(name, 32'(cyc), 32'(DEPTH));
  endtask

  task automatic do_req(input logic we, input logic [7:0] a, input logic [3:0] be,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd);
    int  t_acc = 0;
    int  n     = 0;
    bit  got   = 0;
    lat = -1;
    rd  = 'x;
    @(posedge clk); #1;
    req_we = we; req_addr = a; req_be = be; req_wdata = wd; req_valid = 1'b1;
    while (!got && n < 64) begin
      @(negedge clk);
      n++;
      if (req_ready) begin got = 1; t_acc = cyc; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!got) begin
      chk("accept_timeout", {29'h0, dbg_state}, 32'hFFFF_FFFF);
      return;
    end
    got = 0; n = 0;
    while (!got && n < 32) begin
      @(negedge clk);
      n++;
      if (rsp_valid) begin got = 1; lat = cyc - t_acc; rd = rsp_rdata; end
    end
    if (!got) chk("rsp_timeout", {29'h0, dbg_state}, 32'hFFFF_FFFF);
  endtask

  // Three full stores with req_valid never dropped between them.
  task automatic b2b();
    int acc [3];
    bit got;
    int n;
    acc = '{0, 0, 0};
    @(posedge clk); #1;
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_we = 1'b1; req_addr = 8'h40 + 8'(k); req_be = 4'hF; req_wdata = $urandom;
      got = 0; n = 0;
      while (!got && n < 40) begin
        @(negedge clk);
        n++;
        if (req_ready) begin got = 1; acc[k] = cyc; end
      end
      if (!got) chk("b2b_timeout", {29'h0, dbg_state}, 32'hFFFF_FFFF);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("b2b_gap1", 32'(acc[1] - acc[0]), 32'd3);
    chk("b2b_gap2", 32'(acc[2] - acc[1]), 32'd3);
    repeat (4) @(posedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int          lat;
    int          t_acc;
    int          n;
    int          rsp_base;
    logic [31:0] rd;
    logic [3:0]  be;
    res = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0;
    repeat (3) @(posedge clk); #1;
    res = 1'b0;
    wait_init("init_cycle");

    do_req(1'b0, 8'h80, 4'h0, 32'h0, lat, rd);
    chk("load80_data", rd, 32'h0000_0000);
    chk("load80_lat", 32'(lat), 32'd3);

    do_req(1'b1, 8'h10, 4'hF, 32'hDEAD_BEEF, lat, rd);
    chk("full_lat", 32'(lat), 32'd2);
    chk("full_data", rd, 32'hDEAD_BEEF);
    do_req(1'b0, 8'h10, 4'h0, 32'h0, lat, rd);
    chk("load10_lat", 32'(lat), 32'd3);
    chk("load10_data", rd, 32'hDEAD_BEEF);

    do_req(1'b1, 8'h10, 4'b0101, 32'h1122_3344, lat, rd);
    chk("part_lat", 32'(lat), 32'd4);
    chk("part_data", rd, 32'hDE22_BE44);
    do_req(1'b0, 8'h10, 4'h0, 32'h0, lat, rd);
    chk("part_readback", rd, 32'hDE22_BE44);

    do_req(1'b1, 8'h10, 4'h0, 32'h5555_5555, lat, rd);
    chk("be0_lat", 32'(lat), 32'd1);
    chk("be0_data", rd, 32'hDE22_BE44);
    do_req(1'b0, 8'h10, 4'h0, 32'h0, lat, rd);
    chk("be0_readback", rd, 32'hDE22_BE44);

    b2b();

    // Random traffic over a small address pool so hazards repeat.
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 3))
        0:       be = 4'h0;
        1:       be = 4'hF;
        default: be = 4'($urandom_range(0, 15));
      endcase
      do_req(1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7)),
             be, $urandom, lat, rd);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Reset while a partial store sits in its write cycle.
    do_req(1'b1, 8'h20, 4'hF, 32'hCAFE_F00D, lat, rd);
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 8'h20; req_be = 4'b0011; req_wdata = 32'h1234_5678; req_valid = 1'b1;
    n = 0; t_acc = -1;
    while (t_acc < 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (req_ready) t_acc = cyc;
    end
    if (t_acc < 0) chk("mid_accept_timeout", {29'h0, dbg_state}, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    res = 1'b1;
    rsp_base = rsp_cnt;
    repeat (2) @(posedge clk); #1;
    res = 1'b0;
    wait_init("reinit_cycle");
    chk("mid_no_rsp", 32'(rsp_cnt - rsp_base), 32'd0);
    do_req(1'b0, 8'h20, 4'h0, 32'h0, lat, rd);
    chk("mid_readback", rd, 32'h0000_0000);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop if something hangs beyond every bounded wait.
  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Request-side controller placed directly upstream of the 256×32 word SRAM. It accepts single load/store requests from the CPU load-store path over a valid/ready handshake and sequences the SRAM's `we`/`addr`/`data_in` pins. It performs read-modify-write for byte-masked stores, since the SRAM has no byte enables. After reset it clears the whole array to zero before accepting traffic.

## Interface
Parameters:
- `ADDR_W`, 8: SRAM word-address width; depth = 2^ADDR_W.
- `DATA_W`, 32: word width; must be a multiple of 8.
- `INIT_CLEAR`, 1: 1 = zero-fill the array after reset; 0 = go straight to idle.

Ports:
- `clk`  in  1  : single clock; all state updates on the rising edge.
- `res`  in  1  : reset, synchronous, active-high.
- `req_valid`  in  1  : request present.
- `req_ready`  out  1  : controller can accept; high only in IDLE.
- `req_we`  in  1  : 1 = store, 0 = load.
- `req_addr`  in  ADDR_W  : word address.
- `req_be`  in  DATA_W/8  : byte enables for a store; ignored for a load.
- `req_wdata`  in  DATA_W  : store data.
- `rsp_valid`  out  1  : one-cycle completion pulse; no backpressure.
- `rsp_rdata`  out  DATA_W  : load data, or the word actually written for a store.
- `init_done`  out  1  : high once the clear is complete; stays high until the next reset.
- `sram_we`  out  1  : SRAM write enable, active-high.
- `sram_addr`  out  ADDR_W  : SRAM address.
- `sram_wdata`  out  DATA_W  : SRAM write data.
- `sram_rdata`  in  DATA_W  : SRAM read data, valid in the cycle after the address is presented with `sram_we=0`.

## Operation
- FSM states and their transitions:
  - CLEAR → IDLE after the last address is written.
  - IDLE → RD, WR or RSP on acceptance.
  - RD → RD_WAIT.
  - RD_WAIT → RSP (load) or MERGE_WR (partial store).
  - WR → RSP.
  - MERGE_WR → RSP.
  - RSP → IDLE.
- CLEAR:
  - Drives `sram_we=1` and `sram_wdata=0`.
  - `sram_addr` is a counter running 0..2^ADDR_W−1, one address per cycle.
- Acceptance: occurs when `req_valid && req_ready`. All `req_*` fields are registered at that point; inputs are ignored afterwards.
- Load:
  - RD presents the address with `sram_we=0`.
  - RD_WAIT captures `sram_rdata` into `rsp_rdata`.
  - RSP pulses `rsp_valid`.
- Store with all `req_be` bits set: WR drives `sram_we=1` with `req_wdata`, then RSP.
- Store with a partial `req_be`:
  - RD, then RD_WAIT merges the data per byte: byte i = `req_be[i]` ? `req_wdata` byte i : `sram_rdata` byte i.
  - The merged word is registered.
  - MERGE_WR writes it, then RSP.
- Store with `req_be=0`: goes directly IDLE → RSP. No SRAM write occurs, and `rsp_rdata` is unchanged.
- For stores, `rsp_rdata` = the word written.
- `sram_we` is high only in CLEAR, WR and MERGE_WR. It is forced to 0 in any cycle where `res=1`.

## Timing
- Reset values:
  - `req_ready`, `rsp_valid`, `init_done`, `sram_we` = 0.
  - `sram_addr`, `sram_wdata`, `rsp_rdata` = 0.
  - State = CLEAR (or IDLE if `INIT_CLEAR=0`).
- Clear timing, with cycle 0 = the first cycle with `res=0`:
  - Address k is written in cycle k.
  - Cycle 2^ADDR_W: IDLE, `init_done=1`, `req_ready=1` (256 cycles at the defaults).
- Latency, with acceptance in cycle T:
  - Full store: write edge ends T+1; `rsp_valid` in T+2.
  - Load: `rsp_valid` in T+3.
  - Partial store: write in T+3; `rsp_valid` in T+4.
  - `be=0` store: `rsp_valid` in T+1.
- Back-to-back requests: `req_ready` returns high in the cycle after RSP. A request held valid is accepted then; no gap is needed on the requester side.
- Address wrap: `req_addr` uses exactly ADDR_W bits; no range error is possible.
- Reset mid-operation: the in-flight request is dropped with no response. The SRAM content at that address is whatever the last completed edge wrote. The clear then restarts from address 0.
- `res` asserted during CLEAR restarts the counter at 0.

## Structure
- Shared package `sram_ctrl_pkg`:
  - state encoding (7 states, 3-bit);
  - `ADDR_W`/`DATA_W` defaults;
  - `BE_W = DATA_W/8`;
  - a full-mask constant.
- Sub-module `sram_byte_merge`: combinational per-byte mux of `old`/`new`/`be` → merged word. It is reused later by the cache fill path.
- Top-level `sram_ctrl` contains the FSM, request register, clear counter and response register.

## Test plan
- Reset then idle:
  - Addresses 0..255 are written with 0, one per cycle.
  - `init_done` and `req_ready` rise in cycle 256.
  - A load of 0x80 returns 0x00000000.
- Full store 0xDEADBEEF to 0x10, then a load of 0x10:
  - The store's `rsp_valid` arrives at T+2.
  - The load returns 0xDEADBEEF at T+3.
- Partial store `be=4'b0101`, `wdata=0x11223344`, over 0xDEADBEEF at 0x10 → the written word and the next read both equal 0xDE22BE44.
- Store with `be=0` to 0x10 → `rsp_valid` at T+1, `sram_we` never asserted, content unchanged.
- `req_valid` held high across 3 requests:
  - Each is accepted exactly once, in the cycle after the previous RSP.
  - `req_ready` is low in all other cycles.
- `res` pulsed during MERGE_WR:
  - No `rsp_valid` is produced.
  - The clear restarts at address 0.
  - `init_done` returns only after the full clear.
